// File: rtl/frame_buffer_clearer_pkg.sv
// Shared constants and types for the frame buffer burst masters (clearer and reader).
// Sizes are in bytes unless the name says words; an Avalon word is 64 bits.
package frame_buffer_clearer_pkg;

    localparam logic [29:0] FRAME_BUFFER_ADDRESS = 30'h3800_0000;
    localparam int unsigned FRAME_BUFFER_LENGTH  = 800 * 480 * 4;
    localparam int unsigned BYTES_PER_WORD       = 8;
    localparam int unsigned BURSTCOUNT_WIDTH     = 8;
    localparam int unsigned REMAINING_WIDTH      = 27;
    localparam int unsigned WORD_ADDR_WIDTH      = 29;

    typedef enum logic [1:0] {
        StIdle,
        StWrite,
        StFinish
    } state_e;

    // Beats in the next burst: the full burst length, or whatever is left.
    function automatic logic [BURSTCOUNT_WIDTH-1:0] burst_size(
        input logic [REMAINING_WIDTH-1:0] remaining,
        input int unsigned                max_beats
    );
        if (32'(remaining) < max_beats) begin
            return BURSTCOUNT_WIDTH'(remaining);
        end
        return BURSTCOUNT_WIDTH'(max_beats);
    endfunction

endpackage

// File: rtl/frame_buffer_clearer.sv
// Avalon-MM burst write master that fills the frame buffer with one colour,
// two pixels per 64-bit beat, bursts issued back to back.
module frame_buffer_clearer
    import frame_buffer_clearer_pkg::*;
#(
    parameter logic [29:0] ADDRESS      = FRAME_BUFFER_ADDRESS,
    parameter int unsigned LENGTH       = FRAME_BUFFER_LENGTH,
    parameter int unsigned BURST_LENGTH = 16
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic [31:0] color,
    output logic        busy,
    output logic        done,
    output logic [28:0] address,
    output logic [7:0]  burstcount,
    input  logic        waitrequest,
    output logic [63:0] writedata,
    output logic [7:0]  byteenable,
    output logic        write
);

    localparam logic [REMAINING_WIDTH-1:0] WORDS =
        REMAINING_WIDTH'(LENGTH / BYTES_PER_WORD);
    localparam logic [WORD_ADDR_WIDTH-1:0] BASE_WORD = WORD_ADDR_WIDTH'(ADDRESS >> 3);

    state_e                       state_q, state_d;
    logic                         busy_q, busy_d;
    logic                         done_q, done_d;
    logic                         write_q, write_d;
    logic [WORD_ADDR_WIDTH-1:0]   address_q, address_d;
    logic [BURSTCOUNT_WIDTH-1:0]  burstcount_q, burstcount_d;
    logic [63:0]                  writedata_q, writedata_d;
    logic [REMAINING_WIDTH-1:0]   remaining_q, remaining_d;
    logic [BURSTCOUNT_WIDTH-1:0]  beat_q, beat_d;
    logic [REMAINING_WIDTH-1:0]   remaining_dec;
    logic [BURSTCOUNT_WIDTH-1:0]  beat_inc;

    always_comb begin
        state_d       = state_q;
        busy_d        = busy_q;
        done_d        = 1'b0;
        write_d       = write_q;
        address_d     = address_q;
        burstcount_d  = burstcount_q;
        writedata_d   = writedata_q;
        remaining_d   = remaining_q;
        beat_d        = beat_q;
        remaining_dec = remaining_q - 1'b1;
        beat_inc      = beat_q + 1'b1;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    writedata_d  = {color, color};
                    address_d    = BASE_WORD;
                    remaining_d  = WORDS;
                    burstcount_d = burst_size(WORDS, BURST_LENGTH);
                    beat_d       = '0;
                    write_d      = 1'b1;
                    busy_d       = 1'b1;
                    state_d      = StWrite;
                end
            end
            StWrite: begin
                // Stalled beats leave every output untouched.
                if (!waitrequest) begin
                    beat_d      = beat_inc;
                    remaining_d = remaining_dec;
                    if (beat_inc == burstcount_q) begin
                        if (remaining_dec == '0) begin
                            write_d = 1'b0;
                            state_d = StFinish;
                        end else begin
                            address_d    = address_q + WORD_ADDR_WIDTH'(burstcount_q);
                            burstcount_d = burst_size(remaining_dec, BURST_LENGTH);
                            beat_d       = '0;
                        end
                    end
                end
            end
            StFinish: begin
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = StIdle;
            end
            default: begin
                write_d = 1'b0;
                busy_d  = 1'b0;
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= StIdle;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            write_q      <= 1'b0;
            address_q    <= '0;
            burstcount_q <= '0;
            writedata_q  <= '0;
            remaining_q  <= '0;
            beat_q       <= '0;
        end else begin
            state_q      <= state_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            write_q      <= write_d;
            address_q    <= address_d;
            burstcount_q <= burstcount_d;
            writedata_q  <= writedata_d;
            remaining_q  <= remaining_d;
            beat_q       <= beat_d;
        end
    end

    assign busy       = busy_q;
    assign done       = done_q;
    assign write      = write_q;
    assign address    = address_q;
    assign burstcount = burstcount_q;
    assign writedata  = writedata_q;
    assign byteenable = 8'hFF;

endmodule

// File: tb/tb_frame_buffer_clearer.sv
// Directed bench for frame_buffer_clearer: three configurations share one clock and
// a select that routes start and the observed outputs.
module tb_frame_buffer_clearer;

    logic        clock = 1'b0;
    logic        reset;
    logic        start;
    logic [31:0] color;
    logic        waitrequest;
    logic [1:0]  sel;

    logic        start_v      [3];
    logic        busy_v       [3];
    logic        done_v       [3];
    logic [28:0] address_v    [3];
    logic [7:0]  burstcount_v [3];
    logic [63:0] writedata_v  [3];
    logic [7:0]  byteenable_v [3];
    logic        write_v      [3];

    logic        busy, done, write;
    logic [28:0] address;
    logic [7:0]  burstcount, byteenable;
    logic [63:0] writedata;

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    assign start_v[0] = start && (sel == 2'd0);
    assign start_v[1] = start && (sel == 2'd1);
    assign start_v[2] = start && (sel == 2'd2);

    assign busy       = busy_v[sel];
    assign done       = done_v[sel];
    assign write      = write_v[sel];
    assign address    = address_v[sel];
    assign burstcount = burstcount_v[sel];
    assign writedata  = writedata_v[sel];
    assign byteenable = byteenable_v[sel];

    // 16 words, bursts of 4 at word 0x20
    frame_buffer_clearer #(.ADDRESS(30'h100), .LENGTH(128), .BURST_LENGTH(4)) u_dut_a (
        .clock(clock), .reset(reset), .start(start_v[0]), .color(color),
        .busy(busy_v[0]), .done(done_v[0]), .address(address_v[0]),
        .burstcount(burstcount_v[0]), .waitrequest(waitrequest),
        .writedata(writedata_v[0]), .byteenable(byteenable_v[0]), .write(write_v[0])
    );

    // 10 words, final partial burst of 2
    frame_buffer_clearer #(.ADDRESS(30'h100), .LENGTH(80), .BURST_LENGTH(4)) u_dut_b (
        .clock(clock), .reset(reset), .start(start_v[1]), .color(color),
        .busy(busy_v[1]), .done(done_v[1]), .address(address_v[1]),
        .burstcount(burstcount_v[1]), .waitrequest(waitrequest),
        .writedata(writedata_v[1]), .byteenable(byteenable_v[1]), .write(write_v[1])
    );

    // Default base address and burst length over the first eight scanlines
    frame_buffer_clearer #(.LENGTH(800 * 4 * 8)) u_dut_c (
        .clock(clock), .reset(reset), .start(start_v[2]), .color(color),
        .busy(busy_v[2]), .done(done_v[2]), .address(address_v[2]),
        .burstcount(burstcount_v[2]), .waitrequest(waitrequest),
        .writedata(writedata_v[2]), .byteenable(byteenable_v[2]), .write(write_v[2])
    );

    task automatic check(input string tag, input logic [63:0] observed,
                         input logic [63:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, observed, expected);
        end
    endtask

    function automatic int min_int(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

    // Starts a clear and tracks it beat by beat against a reference burst sequence.
    task automatic run_clear(input string tag, input int n_words, input logic [28:0] base,
                             input int bl, input logic [31:0] col, input bit rand_wait,
                             input int restart_cyc, input int reset_beat,
                             input logic [28:0] exp_last_addr);
        int          beats = 0, in_burst = 0, bursts = 0, dones = 0, gaps = 0;
        int          done_cyc = -1, first_wr = -1, rem = n_words, exp_bc;
        logic [28:0] exp_addr = base, last_addr = '0;
        bit          finished = 1'b0;

        exp_bc = min_int(bl, rem);
        @(negedge clock);
        start       = 1'b1;
        color       = col;
        waitrequest = 1'b0;
        for (int cyc = 1; cyc <= n_words * 4 + 20 && !finished; cyc++) begin
            @(negedge clock);
            start = 1'b0;
            if (cyc == restart_cyc) begin
                start = 1'b1;
                color = 32'hFFFF_FFFF;
            end
            waitrequest = rand_wait ? 1'($urandom_range(0, 1)) : 1'b0;
            if (first_wr > 0 && beats < n_words && !write) gaps++;
            if (write) begin
                if (first_wr < 0) first_wr = cyc;
                check({tag, ".address"}, 64'(address), 64'(exp_addr));
                check({tag, ".burstcount"}, 64'(burstcount), 64'(exp_bc));
                check({tag, ".writedata"}, writedata, {col, col});
                if (!waitrequest) begin
                    beats++;
                    rem--;
                    in_burst++;
                    if (in_burst == exp_bc) begin
                        bursts++;
                        last_addr = exp_addr;
                        in_burst  = 0;
                        exp_addr  = exp_addr + 29'(exp_bc);
                        exp_bc    = min_int(bl, rem);
                    end
                    if (beats == reset_beat) begin
                        reset = 1'b1;
                        @(negedge clock);
                        reset = 1'b0;
                        check({tag, ".rst_write"}, 64'(write), 64'd0);
                        check({tag, ".rst_busy"}, 64'(busy), 64'd0);
                        check({tag, ".rst_done"}, 64'(done), 64'd0);
                        check({tag, ".rst_address"}, 64'(address), 64'd0);
                        return;
                    end
                end
            end
            if (done) begin
                dones++;
                if (done_cyc < 0) done_cyc = cyc;
                check({tag, ".busy_at_done"}, 64'(busy), 64'd0);
            end
            if (done_cyc > 0 && cyc >= done_cyc + 2) finished = 1'b1;
        end
        check({tag, ".finished"}, 64'(finished), 64'd1);
        check({tag, ".beats"}, 64'(beats), 64'(n_words));
        check({tag, ".bursts"}, 64'(bursts), 64'((n_words + bl - 1) / bl));
        check({tag, ".dones"}, 64'(dones), 64'd1);
        check({tag, ".first_write"}, 64'(first_wr), 64'd1);
        check({tag, ".gaps"}, 64'(gaps), 64'd0);
        check({tag, ".last_addr"}, 64'(last_addr), 64'(exp_last_addr));
        if (!rand_wait) check({tag, ".done_cycle"}, 64'(done_cyc), 64'(n_words + 2));
    endtask

    initial begin
        reset       = 1'b1;
        start       = 1'b0;
        color       = 32'h1234_5678;
        waitrequest = 1'b0;
        sel         = 2'd0;
        repeat (3) @(negedge clock);
        check("reset.write", 64'(write), 64'd0);
        check("reset.busy", 64'(busy), 64'd0);
        check("reset.done", 64'(done), 64'd0);
        check("reset.address", 64'(address), 64'd0);
        check("reset.burstcount", 64'(burstcount), 64'd0);
        check("reset.writedata", writedata, 64'd0);
        check("reset.byteenable", 64'(byteenable), 64'hFF);
        @(negedge clock);
        reset = 1'b0;

        run_clear("full16", 16, 29'h20, 4, 32'h00FF_00FF, 1'b0, -1, -1, 29'h2C);
        sel = 2'd1;
        run_clear("partial10", 10, 29'h20, 4, 32'h00FF_00FF, 1'b0, -1, -1, 29'h28);
        sel = 2'd0;
        run_clear("stalls", 16, 29'h20, 4, 32'h00FF_00FF, 1'b1, -1, -1, 29'h2C);
        run_clear("restart", 16, 29'h20, 4, 32'h00FF_00FF, 1'b0, 5, -1, 29'h2C);
        run_clear("reset6", 16, 29'h20, 4, 32'h00FF_00FF, 1'b0, -1, 6, 29'h2C);
        run_clear("after_reset", 16, 29'h20, 4, 32'hA5C3_0F81, 1'b0, -1, -1, 29'h2C);
        check("after_reset.byteenable", 64'(byteenable), 64'hFF);
        sel = 2'd2;
        run_clear("default", 3200, 29'h0700_0000, 16, 32'h8040_2010, 1'b0, -1, -1,
                  29'h0700_0000 + 29'd199 * 29'd16);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
